// File: rtl/dtc_vote_collector_if.sv
// Label-in / result-out handshake bundle for the vote collector.
// Ports: in_valid/in_ready/inp/flush (label side), out_valid/out_ready/outp/out_count/out_total (result side).
// slave = collector side, master = the driver of labels and the sink of results.
interface dtc_vote_collector_if #(
  parameter int CNT_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       inp;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       outp;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_total;

  modport slave (
    input  in_valid, inp, flush, out_ready,
    output in_ready, out_valid, outp, out_count, out_total
  );

  modport master (
    output in_valid, inp, flush, out_ready,
    input  in_ready, out_valid, outp, out_count, out_total
  );
endinterface

// File: rtl/dtc_vote_collector.sv
// Accumulates a per-class histogram of 3-bit labels over WINDOW samples (or until flush)
// and reports the majority class; a result appears NUM_CLASSES+1 cycles after the last accept.
// Labels are refused while scanning or while the result waits for out_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport of dtc_vote_collector_if).
module dtc_vote_collector #(
  parameter  int NUM_CLASSES = 8,
  parameter  int WINDOW      = 16,
  localparam int CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dtc_vote_collector_if.slave   bus
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;      // keeps in_ready low until the first clock after reset
  logic [CNT_W-1:0] r_cnt [NUM_CLASSES];
  logic [CNT_W-1:0] r_total;
  logic [2:0]       r_idx;
  logic [2:0]       r_best_cls;
  logic [CNT_W-1:0] r_best_cnt;
  logic [2:0]       r_outp;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] r_out_total;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_close;
  logic w_last_idx;
  logic w_cand_gt;
  logic w_handshake;

  assign w_accept    = bus.in_valid & w_in_ready;
  // Window closes on the accept that fills it, or on a flush that has at least
  // one sample to report (a same-cycle accept counts as that sample).
  assign w_close     = (w_accept && (r_total == CNT_W'(WINDOW - 1))) ||
                       (bus.flush && (w_accept || (r_total != '0)));
  assign w_last_idx  = (r_idx == 3'(NUM_CLASSES - 1));
  // Strictly greater: ties keep the earlier (lower) class.
  assign w_cand_gt   = (r_cnt[r_idx] > r_best_cnt);
  assign w_handshake = w_out_valid & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_close)     w_state_nxt = SCAN;
      SCAN:    if (w_last_idx)  w_state_nxt = OUT;
      OUT:     if (w_handshake) w_state_nxt = ACCUM;
      default:                  w_state_nxt = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACCUM:   w_in_ready  = r_live;
      OUT:     w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Histogram, scan and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
      r_total     <= '0;
      r_idx       <= '0;
      r_best_cls  <= '0;
      r_best_cnt  <= '0;
      r_outp      <= '0;
      r_out_count <= '0;
      r_out_total <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ACCUM: begin
          // Scan bookkeeping is primed while accumulating so SCAN starts clean.
          r_idx      <= '0;
          r_best_cls <= '0;
          r_best_cnt <= '0;
          if (w_accept) begin
            r_cnt[bus.inp] <= r_cnt[bus.inp] + CNT_W'(1);
            r_total        <= r_total + CNT_W'(1);
          end
        end
        SCAN: begin
          if (w_cand_gt) begin
            r_best_cls <= r_idx;
            r_best_cnt <= r_cnt[r_idx];
          end
          r_idx <= r_idx + 3'd1;
          if (w_last_idx) begin
            // Fold in the final candidate directly when latching the result.
            r_outp      <= w_cand_gt ? r_idx        : r_best_cls;
            r_out_count <= w_cand_gt ? r_cnt[r_idx] : r_best_cnt;
            r_out_total <= r_total;
          end
        end
        OUT: begin
          if (w_handshake) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
            r_total <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.outp      = r_outp;
  assign bus.out_count = r_out_count;
  assign bus.out_total = r_out_total;

endmodule
